// File: rtl/pwm_duty_meter.sv
// PWM duty meter: reports high time and period of pwm_in in clk cycles.
// Define PWM_METER_FILTER_EN to add a FILT_LEN-cycle glitch filter on the line.
module pwm_duty_meter #(
    parameter int W        = 10,
    parameter int TIMEOUT  = 1023,
    parameter int FILT_LEN = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         pwm_in,
    output logic [W-1:0] high_cnt,
    output logic [W-1:0] period_cnt,
    output logic         valid,
    output logic         stuck,
    output logic         stuck_level
);

    typedef enum logic {IDLE, MEAS} state_t;

    localparam logic [W-1:0] TO  = W'(TIMEOUT);
    localparam logic [W-1:0] ONE = W'(1);

    if (TIMEOUT < 2 || TIMEOUT > (2**W) - 1 || FILT_LEN < 2) begin : g_bad_cfg
        $error("pwm_duty_meter: parameter out of range");
    end

    logic         sync1, sync2;
    logic         lvl, lvl_q, rise;
    state_t       state, state_d;
    logic [W-1:0] cnt_p, cnt_p_d;
    logic [W-1:0] cnt_h, cnt_h_d;
    logic [W-1:0] cnt_i, cnt_i_d;
    logic [W-1:0] high_d, period_d;
    logic         valid_d, stuck_d, stuck_lvl_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef PWM_METER_FILTER_EN
    localparam int            FW    = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0] FLAST = FW'(FILT_LEN - 1);

    logic [FW-1:0] fcnt;
    logic          flvl;

    // lvl follows sync2 only after FILT_LEN consecutive disagreeing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= '0;
            flvl <= 1'b0;
        end else if (sync2 == flvl) begin
            fcnt <= '0;
        end else if (fcnt == FLAST) begin
            fcnt <= '0;
            flvl <= sync2;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    assign lvl = flvl;
`else
    assign lvl = sync2;
`endif

    assign rise = lvl & ~lvl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q       <= 1'b0;
            state       <= IDLE;
            cnt_p       <= '0;
            cnt_h       <= '0;
            cnt_i       <= '0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            lvl_q       <= lvl;
            state       <= state_d;
            cnt_p       <= cnt_p_d;
            cnt_h       <= cnt_h_d;
            cnt_i       <= cnt_i_d;
            high_cnt    <= high_d;
            period_cnt  <= period_d;
            valid       <= valid_d;
            stuck       <= stuck_d;
            stuck_level <= stuck_lvl_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_p_d     = cnt_p;
        cnt_h_d     = cnt_h;
        cnt_i_d     = cnt_i;
        high_d      = high_cnt;
        period_d    = period_cnt;
        valid_d     = 1'b0;
        stuck_d     = stuck;
        stuck_lvl_d = stuck_level;
        if (!en) begin
            state_d = IDLE;
            cnt_p_d = '0;
            cnt_h_d = '0;
            cnt_i_d = '0;
            stuck_d = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state_d = MEAS;
                        cnt_p_d = ONE;
                        cnt_h_d = ONE;
                        cnt_i_d = '0;
                    end else if (cnt_i != TO) begin
                        // idle counter saturates so stuck fires once per entry
                        cnt_i_d = cnt_i + ONE;
                        if (cnt_i == TO - ONE) begin
                            stuck_d     = 1'b1;
                            stuck_lvl_d = lvl;
                        end
                    end
                end
                MEAS: begin
                    if (rise) begin
                        high_d   = cnt_h;
                        period_d = cnt_p;
                        valid_d  = 1'b1;
                        stuck_d  = 1'b0;
                        cnt_p_d  = ONE;
                        cnt_h_d  = ONE;
                    end else if (cnt_p == TO) begin
                        stuck_d     = 1'b1;
                        stuck_lvl_d = lvl;
                        state_d     = IDLE;
                        cnt_p_d     = '0;
                        cnt_h_d     = '0;
                        cnt_i_d     = '0;
                    end else begin
                        cnt_p_d = cnt_p + ONE;
                        if (lvl) begin
                            cnt_h_d = cnt_h + ONE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomized bench for pwm_duty_meter against a run-length/timestamp reference.
module tb_pwm_duty_meter;

    localparam int W  = 10;
    localparam int TO = 1023;
    localparam int FL = 3;
`ifdef PWM_METER_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int LAT    = FILT ? 3 + FL : 3;
    localparam int MINRUN = FILT ? FL : 1;

    typedef struct {
        int h;
        int p;
        int t;
    } meas_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         pwm_in = 1'b0;
    logic [W-1:0] high_cnt, period_cnt;
    logic         valid, stuck, stuck_level;

    int    n_run = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    n_dbl = 0;
    logic  valid_seen = 1'b0;
    meas_t obs_q[$];
    meas_t exp_q[$];

    // reference model state: effective line level and edge timestamps
    bit m_lvl = 1'b0;
    bit m_win = 1'b0;
    int m_rise = 0;
    int m_fall = 0;
    int last_h = 0;
    int last_p = 0;

    pwm_duty_meter #(.W(W), .TIMEOUT(TO), .FILT_LEN(FL)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .pwm_in(pwm_in),
        .high_cnt(high_cnt),
        .period_cnt(period_cnt),
        .valid(valid),
        .stuck(stuck),
        .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && valid)
            obs_q.push_back('{int'(high_cnt), int'(period_cnt), cyc});
        if (!rst && valid && valid_seen)
            n_dbl <= n_dbl + 1;
        valid_seen <= !rst && valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // A window closes on each rise; it is published only if it was open,
    // enabled, and no longer than TO cycles.
    task automatic model_edge(input bit lvl, input int t);
        if (lvl && !m_lvl) begin
            if (m_win && en && (t - m_rise) <= TO) begin
                exp_q.push_back('{m_fall - m_rise, t - m_rise, t + LAT});
                last_h = m_fall - m_rise;
                last_p = t - m_rise;
            end
            m_win  = en;
            m_rise = t;
        end else if (!lvl && m_lvl) begin
            m_fall = t;
        end
        m_lvl = lvl;
    endtask

    task automatic run(input logic level, input int n);
        bit eff;
        eff = (FILT && n < FL) ? m_lvl : level;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pwm_in = level;
            if (i == 0) model_edge(eff, cyc);
        end
    endtask

    task automatic pulse(input int h, input int l);
        run(1'b1, h);
        run(1'b0, l);
    endtask

    task automatic settle();
        repeat (LAT + 3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if (high_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset high_cnt: got %0d want 0", high_cnt);
        end
        n_run++;
        if (period_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset period_cnt: got %0d want 0", period_cnt);
        end
        n_run++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset valid: got %b want 0", valid);
        end
        n_run++;
        if (stuck !== 1'b0 || stuck_level !== 1'b0) begin
            n_fail++;
            $display("FAIL reset stuck: got %b/%b want 0/0", stuck, stuck_level);
        end
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_idle_stuck();
        repeat (TO - 10) @(posedge clk);
        #1;
        n_run++;
        if (stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_early stuck: got %b want 0", stuck);
        end
        repeat (30) @(posedge clk);
        #1;
        n_run++;
        if (stuck !== 1'b1 || stuck_level !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_stuck: got %b/%b want 1/0", stuck, stuck_level);
        end
    endtask

    task automatic test_fixed();
        meas_t o, e;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) pulse(3, 7);
        settle();
        n_run++;
        if (obs_q.size() != 7) begin
            n_fail++;
            $display("FAIL fixed nvalid: got %0d want 7", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_run++;
            if (obs_q[i].h != 3 || obs_q[i].p != 10) begin
                n_fail++;
                $display("FAIL fixed value: got %0d/%0d want 3/10", obs_q[i].h, obs_q[i].p);
            end
            if (i > 0) begin
                n_run++;
                if (obs_q[i].t - obs_q[i-1].t != 10) begin
                    n_fail++;
                    $display("FAIL fixed spacing: got %0d want 10", obs_q[i].t - obs_q[i-1].t);
                end
            end
        end
        n_run++;
        if (stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL fixed stuck_clear: got %b want 0", stuck);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_run++;
            if (o.h != e.h || o.p != e.p || o.t != e.t) begin
                n_fail++;
                $display("FAIL fixed meas: got %0d/%0d@%0d want %0d/%0d@%0d", o.h, o.p, o.t, e.h, e.p, e.t);
            end
        end
    endtask

    task automatic test_step();
        meas_t o, e;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) pulse(3, 7);
        for (int i = 0; i < 4; i++) pulse(7, 3);
        settle();
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i].p == 10) begin
                n_run++;
                if (obs_q[i].h != 3 && obs_q[i].h != 7) begin
                    n_fail++;
                    $display("FAIL step intermediate: got %0d want 3 or 7", obs_q[i].h);
                end
            end
        end
        n_run++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL step nvalid: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_run++;
            if (o.h != e.h || o.p != e.p || o.t != e.t) begin
                n_fail++;
                $display("FAIL step meas: got %0d/%0d@%0d want %0d/%0d@%0d", o.h, o.p, o.t, e.h, e.p, e.t);
            end
        end
    endtask

    task automatic test_random();
        meas_t o, e;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 30; i++)
            pulse($urandom_range(15, MINRUN), $urandom_range(15, MINRUN));
        settle();
        n_run++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random nvalid: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_run++;
            if (o.h != e.h || o.p != e.p || o.t != e.t) begin
                n_fail++;
                $display("FAIL random meas: got %0d/%0d@%0d want %0d/%0d@%0d", o.h, o.p, o.t, e.h, e.p, e.t);
            end
        end
    endtask

    task automatic test_stuck();
        meas_t o, e;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) pulse(3, 7);
        run(1'b1, 1100);
        n_run++;
        if (stuck !== 1'b1 || stuck_level !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_high flag: got %b/%b want 1/1", stuck, stuck_level);
        end
        n_run++;
        if (int'(high_cnt) != last_h || int'(period_cnt) != last_p) begin
            n_fail++;
            $display("FAIL stuck_high hold: got %0d/%0d want %0d/%0d", high_cnt, period_cnt, last_h, last_p);
        end
        run(1'b0, 7);
        n_run++;
        if (stuck !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_persist: got %b want 1", stuck);
        end
        for (int i = 0; i < 3; i++) pulse(3, 7);
        settle();
        n_run++;
        if (stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_clear: got %b want 0", stuck);
        end
        n_run++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stuck nvalid: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_run++;
            if (o.h != e.h || o.p != e.p || o.t != e.t) begin
                n_fail++;
                $display("FAIL stuck meas: got %0d/%0d@%0d want %0d/%0d@%0d", o.h, o.p, o.t, e.h, e.p, e.t);
            end
        end
    endtask

    task automatic test_boundary();
        meas_t o, e;
        obs_q.delete();
        exp_q.delete();
        pulse(5, TO - 5);
        pulse(5, TO - 4);
        run(1'b1, 3);
        run(1'b0, 7);
        settle();
        n_run++;
        if (int'(high_cnt) != 5 || int'(period_cnt) != TO) begin
            n_fail++;
            $display("FAIL boundary period_eq_timeout: got %0d/%0d want 5/%0d", high_cnt, period_cnt, TO);
        end
        n_run++;
        if (stuck !== 1'b1 || stuck_level !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary over_timeout: got %b/%b want 1/0", stuck, stuck_level);
        end
        n_run++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL boundary nvalid: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_run++;
            if (o.h != e.h || o.p != e.p || o.t != e.t) begin
                n_fail++;
                $display("FAIL boundary meas: got %0d/%0d@%0d want %0d/%0d@%0d", o.h, o.p, o.t, e.h, e.p, e.t);
            end
        end
    endtask

    task automatic test_en();
        meas_t o, e;
        obs_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        en = 1'b0;
        m_win = 1'b0;
        run(1'b0, 5);
        n_run++;
        if (stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL en_low stuck: got %b want 0", stuck);
        end
        pulse(3, 7);
        run(1'b1, 3);
        run(1'b0, 7);
        n_run++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL en_low valid: got %0d want 0", obs_q.size());
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) pulse(3, 7);
        settle();
        n_run++;
        if (obs_q.size() != 3) begin
            n_fail++;
            $display("FAIL en_resume nvalid: got %0d want 3", obs_q.size());
        end else if (obs_q[0].h != 3 || obs_q[0].p != 10) begin
            n_fail++;
            $display("FAIL en_resume first: got %0d/%0d want 3/10", obs_q[0].h, obs_q[0].p);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_run++;
            if (o.h != e.h || o.p != e.p || o.t != e.t) begin
                n_fail++;
                $display("FAIL en meas: got %0d/%0d@%0d want %0d/%0d@%0d", o.h, o.p, o.t, e.h, e.p, e.t);
            end
        end
    endtask

    task automatic test_reset_mid();
        meas_t o, e;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 2; i++) pulse(3, 7);
        run(1'b1, 3);
        run(1'b0, 3);
        obs_q.delete();
        exp_q.delete();
        #2;
        rst = 1'b1;
        #1;
        n_run++;
        if (high_cnt !== '0 || period_cnt !== '0) begin
            n_fail++;
            $display("FAIL rstmid outputs: got %0d/%0d want 0/0", high_cnt, period_cnt);
        end
        n_run++;
        if (valid !== 1'b0 || stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid flags: got %b/%b want 0/0", valid, stuck);
        end
        m_win = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        run(1'b0, 4);
        for (int i = 0; i < 3; i++) pulse(3, 7);
        settle();
        n_run++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL rstmid nvalid: got %0d want 2", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_run++;
            if (o.h != e.h || o.p != e.p || o.t != e.t) begin
                n_fail++;
                $display("FAIL rstmid meas: got %0d/%0d@%0d want %0d/%0d@%0d", o.h, o.p, o.t, e.h, e.p, e.t);
            end
        end
    endtask

    task automatic test_glitch();
        meas_t o, e;
        int n_short;
        obs_q.delete();
        exp_q.delete();
        pulse(3, 7);
        for (int i = 0; i < 4; i++) begin
            run(1'b1, 3);
            run(1'b0, 3);
            if (i % 2 == 0) begin
                run(1'b1, 1);
                run(1'b0, 3);
            end else begin
                run(1'b1, 2);
                run(1'b0, 2);
            end
        end
        pulse(3, 7);
        settle();
        n_short = 0;
        for (int i = 1; i < obs_q.size(); i++) begin
            if (obs_q[i].p < 10) n_short++;
            if (FILT) begin
                n_run++;
                if (obs_q[i].h != 3 || obs_q[i].p != 10) begin
                    n_fail++;
                    $display("FAIL glitch filtered: got %0d/%0d want 3/10", obs_q[i].h, obs_q[i].p);
                end
            end
        end
        if (!FILT) begin
            n_run++;
            if (n_short == 0) begin
                n_fail++;
                $display("FAIL glitch unfiltered: got 0 short periods want >0");
            end
        end
        n_run++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL glitch nvalid: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_run++;
            if (o.h != e.h || o.p != e.p || o.t != e.t) begin
                n_fail++;
                $display("FAIL glitch meas: got %0d/%0d@%0d want %0d/%0d@%0d", o.h, o.p, o.t, e.h, e.p, e.t);
            end
        end
    endtask

    task automatic test_back_to_back();
        meas_t o, e;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 12; i++) pulse(MINRUN, MINRUN);
        settle();
        n_run++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b nvalid: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_run++;
            if (o.h != e.h || o.p != e.p || o.t != e.t) begin
                n_fail++;
                $display("FAIL b2b meas: got %0d/%0d@%0d want %0d/%0d@%0d", o.h, o.p, o.t, e.h, e.p, e.t);
            end
        end
        n_run++;
        if (n_dbl != 0) begin
            n_fail++;
            $display("FAIL b2b double_valid: got %0d want 0", n_dbl);
        end
    endtask

    initial begin
        test_reset();
        test_idle_stuck();
        test_fixed();
        test_step();
        test_random();
        test_stuck();
        test_boundary();
        test_en();
        test_reset_mid();
        test_glitch();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
